// File: rtl/fetch_queue.sv
// Instruction fetch front end: block requests to the bus, epoch-tagged
// responses, and a circular instruction queue feeding decode.
module fetch_queue #(
    parameter int ADDR_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int FETCH_WIDTH       = 4,
    parameter int DECODE_WIDTH      = 2,
    parameter int DEPTH             = 16,
    parameter int MAX_OUTSTANDING   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0]                 redirect_pc,
    output logic                                  bus_req_valid,
    output logic [ADDR_WIDTH-1:0]                 bus_req_addr,
    input  logic                                  bus_req_ready,
    input  logic                                  bus_resp_valid,
    input  logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0] bus_resp_data,
    input  logic                                  bus_resp_error,
    output logic [DECODE_WIDTH-1:0]               out_valid,
    output logic [INSTRUCTION_WIDTH*DECODE_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH*DECODE_WIDTH-1:0]    out_pc,
    output logic [DECODE_WIDTH-1:0]               out_has_exception,
    input  logic                                  out_ready,
    output logic                                  perf_queue_full_add
);

    localparam int IW  = INSTRUCTION_WIDTH;
    localparam int OW  = $clog2(FETCH_WIDTH);
    localparam int BB  = OW + 2;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int EW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'((1 << BB) - 1);

    typedef struct packed {
        logic [EW-1:0]         epoch;
        logic [OW-1:0]         off;
        logic [ADDR_WIDTH-1:0] blk;
    } tag_t;

    typedef struct packed {
        logic                  exc;
        logic [ADDR_WIDTH-1:0] pc;
        logic [IW-1:0]         inst;
    } ent_t;

    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [OCW-1:0]        outstanding;
    logic [OCW-1:0]        cur_out;
    logic [EW-1:0]         epoch;
    logic                  halted;
    logic [TPW-1:0]        tag_wr;
    logic [TPW-1:0]        tag_rd;

    tag_t tag_mem [MAX_OUTSTANDING];
    ent_t mem [DEPTH];

    logic [ADDR_WIDTH-1:0] blk;
    logic [OW-1:0]         off;
    logic [31:0]           used;
    logic                  space_ok;
    logic                  base_ok;
    logic                  accept;
    logic                  resp_fire;
    logic                  resp_live;
    tag_t                  resp_tag;
    logic [CW-1:0]         wr_n;
    logic [CW-1:0]         rd_n;

    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
        return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
    endfunction

    assign blk      = pc & BLK_MASK;
    assign off      = pc[BB-1:2];
    assign resp_tag = tag_mem[tag_rd];

    // Request gating: reserved space covers current-epoch blocks in flight
    always_comb begin
        used     = 32'(count) + 32'(cur_out) * 32'(FETCH_WIDTH);
        space_ok = used <= 32'(DEPTH - FETCH_WIDTH);
        base_ok  = rst & ~redirect_valid & ~halted &
                   (outstanding < OCW'(MAX_OUTSTANDING));
    end

    assign bus_req_valid       = base_ok & space_ok;
    assign bus_req_addr        = bus_req_valid ? blk : '0;
    assign perf_queue_full_add = base_ok & ~space_ok;

    assign accept    = bus_req_valid & bus_req_ready;
    assign resp_fire = bus_resp_valid & (outstanding != '0);
    assign resp_live = resp_fire & ~redirect_valid & (resp_tag.epoch == epoch);

    // Entries written and consumed this cycle
    always_comb begin
        wr_n = '0;
        rd_n = '0;
        if (resp_live) begin
            wr_n = bus_resp_error ? CW'(1) :
                   CW'(FETCH_WIDTH) - CW'(resp_tag.off);
        end
        if (out_ready && !redirect_valid) begin
            rd_n = (count < CW'(DECODE_WIDTH)) ? count : CW'(DECODE_WIDTH);
        end
    end

    for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_out
        ent_t e;
        assign e = mem[rd_ptr + PW'(k)];
        assign out_valid[k]         = count > CW'(k);
        assign out_inst[k*IW +: IW] = out_valid[k] ? e.inst : '0;
        assign out_pc[k*ADDR_WIDTH +: ADDR_WIDTH] = out_valid[k] ? e.pc : '0;
        assign out_has_exception[k] = out_valid[k] & e.exc;
    end

    // Storage: tag FIFO push and queue slot writes (no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr] <= '{epoch: epoch, off: off, blk: blk};
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (resp_live && OW'(i) >= resp_tag.off &&
                (!bus_resp_error || OW'(i) == resp_tag.off)) begin
                mem[wr_ptr + PW'(i) - PW'(resp_tag.off)] <= {
                    bus_resp_error,
                    resp_tag.blk + ADDR_WIDTH'(4 * i),
                    bus_resp_error ? {IW{1'b0}} : bus_resp_data[i*IW +: IW]
                };
            end
        end
    end

    // Control state: pc, pointers, counters, epoch and halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            cur_out     <= '0;
            epoch       <= '0;
            halted      <= 1'b0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            outstanding <= outstanding + OCW'(accept) - OCW'(resp_fire);
            if (accept) begin
                tag_wr <= tag_next(tag_wr);
            end
            if (resp_fire) begin
                tag_rd <= tag_next(tag_rd);
            end
            wr_ptr <= wr_ptr + PW'(wr_n);
            if (redirect_valid) begin
                pc      <= redirect_pc;
                epoch   <= epoch + EW'(1);
                halted  <= 1'b0;
                count   <= '0;
                rd_ptr  <= wr_ptr;
                cur_out <= '0;
            end else begin
                if (accept) begin
                    pc <= blk + ADDR_WIDTH'(FETCH_WIDTH * 4);
                end
                count   <= count + wr_n - rd_n;
                rd_ptr  <= rd_ptr + PW'(rd_n);
                cur_out <= cur_out + OCW'(accept) - OCW'(resp_live);
                if (resp_live && bus_resp_error) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus
// hand-written sequences for fill, fault and mid-burst reset.
module tb_fetch_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         bus_req_valid;
    logic [31:0]  bus_req_addr;
    logic         bus_req_ready;
    logic         bus_resp_valid;
    logic [127:0] bus_resp_data;
    logic         bus_resp_error;
    logic [1:0]   out_valid;
    logic [63:0]  out_inst;
    logic [63:0]  out_pc;
    logic [1:0]   out_has_exception;
    logic         out_ready;
    logic         perf_queue_full_add;

    int errors = 0;
    int checks = 0;
    logic [31:0] aq[$];

    fetch_queue dut (
        .clk                 (clk),
        .rst                 (rst),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .bus_req_valid       (bus_req_valid),
        .bus_req_addr        (bus_req_addr),
        .bus_req_ready       (bus_req_ready),
        .bus_resp_valid      (bus_resp_valid),
        .bus_resp_data       (bus_resp_data),
        .bus_resp_error      (bus_resp_error),
        .out_valid           (out_valid),
        .out_inst            (out_inst),
        .out_pc              (out_pc),
        .out_has_exception   (out_has_exception),
        .out_ready           (out_ready),
        .perf_queue_full_add (perf_queue_full_add)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rsp;
        logic        err;
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        perf;
        logic [1:0]  ov;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  exc;
    } vec_t;

    function automatic logic [31:0] f(input logic [31:0] p);
        return p ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input int redir, input int rpc, input int rdy,
                                input int rsp, input int err, input int ordy,
                                input int rv, input int addr, input int perf,
                                input int ov, input int pc0, input int pc1,
                                input int exc);
        vec_t r;
        r.redir = redir[0]; r.rpc = rpc; r.rdy = rdy[0];
        r.rsp = rsp[0]; r.err = err[0]; r.ordy = ordy[0];
        r.rv = rv[0]; r.addr = addr; r.perf = perf[0];
        r.ov = ov[1:0]; r.pc0 = pc0; r.pc1 = pc1; r.exc = exc[1:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rsp, input logic err,
                       input logic ordy);
        logic [31:0] a;
        @(posedge clk);
        #1;
        redirect_valid = rd;
        redirect_pc    = rpc;
        bus_req_ready  = rdy;
        bus_resp_valid = rsp;
        bus_resp_error = err;
        out_ready      = ordy;
        bus_resp_data  = '1;
        if (rsp && aq.size() > 0) begin
            a = aq.pop_front();
            for (int i = 0; i < 4; i++) begin
                bus_resp_data[i*32 +: 32] = f(a + 32'(4 * i));
            end
        end
        @(negedge clk);
        if (bus_req_valid && bus_req_ready) begin
            aq.push_back(bus_req_addr);
        end
    endtask

    task automatic chk_req(input string nm, input logic rv,
                           input logic [31:0] addr, input logic perf);
        chk({nm, " req_valid"}, 32'(bus_req_valid), 32'(rv));
        if (rv) chk({nm, " req_addr"}, bus_req_addr, addr);
        chk({nm, " perf"}, 32'(perf_queue_full_add), 32'(perf));
    endtask

    task automatic chk_out(input string nm, input logic [1:0] ov,
                           input logic [31:0] pc0, input logic [31:0] pc1,
                           input logic [1:0] exc);
        chk({nm, " out_valid"}, 32'(out_valid), 32'(ov));
        if (ov[0]) begin
            chk({nm, " pc0"}, out_pc[31:0], pc0);
            chk({nm, " inst0"}, out_inst[31:0], exc[0] ? 32'h0 : f(pc0));
            chk({nm, " exc0"}, 32'(out_has_exception[0]), 32'(exc[0]));
        end
        if (ov[1]) begin
            chk({nm, " pc1"}, out_pc[63:32], pc1);
            chk({nm, " inst1"}, out_inst[63:32], exc[1] ? 32'h0 : f(pc1));
        end
    endtask

    vec_t tbl [23];

    initial begin
        tbl[0]  = mk(0, 0, 1, 0, 0, 1, 1, 'h80000000, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 1, 1, 'h80000010, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 1, 1, 'h80000020, 0, 3, 'h80000000, 'h80000004, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 1, 'h80000020, 0, 3, 'h80000008, 'h8000000C, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 'h80000020, 0, 3, 'h80000010, 'h80000014, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1, 'h80000020, 0, 3, 'h80000018, 'h8000001C, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 1, 'h80000020, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 'h80000108, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 1, 1, 'h80000100, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 1, 1, 'h80000110, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 'h80000110, 0, 3, 'h80000108, 'h8000010C, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 'h80000110, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 1, 1, 'h80000110, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 0, 1, 1, 'h80000120, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 'h80000200, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 0, 1, 1, 'h80000200, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 1, 0, 0, 1, 1, 'h80000200, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 1, 0, 0, 1, 1, 'h80000210, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 0, 1, 1, 'h80000220, 0, 3, 'h80000200, 'h80000204, 0);
        tbl[22] = mk(1, 'h80000300, 0, 0, 0, 1, 0, 0, 0, 3, 'h80000208, 'h8000020C, 0);

        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_data = '0;
        bus_resp_error = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset req_valid", 32'(bus_req_valid), 32'h0);
        chk("reset req_addr", bus_req_addr, 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset perf", 32'(perf_queue_full_add), 32'h0);
        chk("reset out_pc", out_pc[31:0], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rsp,
                tbl[i].err, tbl[i].ordy);
            chk_req($sformatf("row%0d", i), tbl[i].rv, tbl[i].addr, tbl[i].perf);
            chk_out($sformatf("row%0d", i), tbl[i].ov, tbl[i].pc0,
                    tbl[i].pc1, tbl[i].exc);
        end

        // Fill with decode stalled: reserved space blocks the 5th request
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, '0, 1'b1, aq.size() != 0, 1'b0, 1'b0);
            chk_req($sformatf("fill%0d", c), c < 4,
                    32'h80000300 + 32'(16 * c), c >= 4);
            chk_out($sformatf("fill%0d", c), (c >= 2) ? 2'b11 : 2'b00,
                    32'h80000300, 32'h80000304, 2'b00);
        end
        for (int d = 0; d < 8; d++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_out($sformatf("drain%0d", d), 2'b11,
                    32'h80000300 + 32'(8 * d), 32'h80000304 + 32'(8 * d), 2'b00);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("drained", 2'b00, '0, '0, 2'b00);

        // Access fault: single excepting entry, fetch halts until redirect
        cyc(1'b1, 32'h80000024, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_req("err0", 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_req("err1", 1'b1, 32'h80000020, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_req("err2", 1'b1, 32'h80000030, 1'b0);
        chk_out("err2", 2'b00, '0, '0, 2'b00);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_req("err3", 1'b0, '0, 1'b0);
        chk_out("err3", 2'b01, 32'h80000024, '0, 2'b01);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_req("err4", 1'b0, '0, 1'b0);
        chk_out("err4", 2'b00, '0, '0, 2'b00);
        cyc(1'b1, 32'h80000400, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_req("err5", 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_req("err6", 1'b1, 32'h80000400, 1'b0);

        // Build count=7, outstanding=2, then reset mid-burst
        cyc(1'b1, 32'h80000404, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_req("mid0", 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_req("mid1", 1'b1, 32'h80000400, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_req("mid2", 1'b1, 32'h80000410, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_req("mid3", 1'b1, 32'h80000420, 1'b0);
        chk_out("mid3", 2'b11, 32'h80000404, 32'h80000408, 2'b00);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_req("mid4", 1'b1, 32'h80000430, 1'b0);
        chk_out("mid4", 2'b11, 32'h80000404, 32'h80000408, 2'b00);

        #2;
        rst = 1'b0;
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("midrst req_valid", 32'(bus_req_valid), 32'h0);
        chk("midrst req_addr", bus_req_addr, 32'h0);
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst perf", 32'(perf_queue_full_add), 32'h0);
        aq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_req("late0", 1'b1, 32'h80000000, 1'b0);
        chk_out("late0", 2'b00, '0, '0, 2'b00);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_req("late1", 1'b1, 32'h80000000, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_req("late2", 1'b1, 32'h80000010, 1'b0);
        chk_out("late2", 2'b00, '0, '0, 2'b00);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("late3", 2'b11, 32'h80000000, 32'h80000004, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Decoupled, parametrised instruction-fetch front end. It issues aligned block reads to the instruction bus with up to MAX_OUTSTANDING requests in flight, and buffers the returned instructions in a DEPTH-entry circular queue. It delivers up to DECODE_WIDTH instructions per cycle to decode. A redirect from commit flushes the queue and drops stale in-flight responses using an epoch tag.

Parameters:
ADDR_WIDTH, 32, address width
INSTRUCTION_WIDTH, 32, instruction width
FETCH_WIDTH, 4, instructions per bus block (power of 2)
DECODE_WIDTH, 2, max instructions delivered per cycle (≤ FETCH_WIDTH)
DEPTH, 16, queue entries (power of 2, ≥ 2*FETCH_WIDTH)
MAX_OUTSTANDING, 2, max in-flight bus requests
RESET_PC, 32'h80000000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_WIDTH  restart PC
bus_req_valid  out  1  read request
bus_req_addr  out  ADDR_WIDTH  block-aligned address
bus_req_ready  in  1  request accepted when valid&ready
bus_resp_valid  in  1  in-order response
bus_resp_data  in  INSTRUCTION_WIDTH*FETCH_WIDTH  slot i at [i*IW +: IW]
bus_resp_error  in  1  access fault for the block
out_valid  out  DECODE_WIDTH  slot k valid
out_inst  out  INSTRUCTION_WIDTH*DECODE_WIDTH  instructions
out_pc  out  ADDR_WIDTH*DECODE_WIDTH  PCs
out_has_exception  out  DECODE_WIDTH  fetch fault marker
out_ready  in  1  decode consumes all valid slots
perf_queue_full_add  out  1  pulse: request blocked by lack of queue space

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, count=0, rd/wr ptr=0, outstanding=0, epoch=0, halted=0. All outputs 0.
- Block address blk = pc with low log2(FETCH_WIDTH*4) bits cleared. Start offset off = pc[log2(FW*4)-1:2].
- bus_req_valid = !redirect_valid & !halted & outstanding<MAX_OUTSTANDING & (DEPTH-count-reserved) ≥ FETCH_WIDTH.
  - reserved = FETCH_WIDTH × (outstanding requests of the current epoch).
  - bus_req_addr = blk.
- Request accepted: pc <= blk+FETCH_WIDTH*4. Push {epoch, off} into an internal tag FIFO of depth MAX_OUTSTANDING.
- perf_queue_full_add = 1 when every term of bus_req_valid except the space check is true and the space check fails.
- Response: pop the tag. If the tag epoch ≠ epoch, discard the response.
  - Otherwise write slots off..FETCH_WIDTH-1 into the queue in order, with pc = blk+4*i.
  - If bus_resp_error: write only slot off, with has_exception=1 and inst=0. Set halted=1; no further requests until redirect.
- outstanding: +1 on accept, −1 on response; both in the same cycle → unchanged. A response with outstanding=0 is a protocol violation; the response is ignored.
- out_valid[k] = (count > k). Slot k shows the entry at rd_ptr+k (mod DEPTH).
- out_ready=1: rd_ptr += min(count, DECODE_WIDTH) and count decreases by the same amount. A write and a read in the same cycle update count by the net amount.
- Redirect (highest priority): count=0, rd_ptr=wr_ptr, pc=redirect_pc, epoch+=1 (wraps; the epoch counter has ≥ log2(MAX_OUTSTANDING)+1 bits), halted=0.
  - No request is issued that cycle.
  - A response arriving that cycle is popped and dropped.
  - out_ready is ignored that cycle.
  - outstanding is still tracked.
- Pointers wrap mod DEPTH. The space check guarantees a write never overflows.
- No combinational path from bus_resp_* to out_*. Write data becomes visible the cycle after the response.

Test Plan:
- Reset, bus_req_ready=1, responses after 1 cycle → requests at 0x80000000 then 0x80000010. Then out slots pc 0x80000000/0x80000004 with out_ready=1 every cycle; ordering is preserved.
- Redirect to 0x80000108 → next request addr 0x80000100. Only slots 2,3 (pc 0x80000108, 0x8000010C) are enqueued.
- Two requests in flight, redirect before either response → both responses are dropped, count stays 0, outstanding returns to 0, and fetch resumes at redirect_pc.
- out_ready=0 permanently → queue fills to 16, bus_req_valid deasserts with reserved space honoured, and perf_queue_full_add=1 while blocked. No entry is lost or overwritten.
- bus_resp_error on block 0x80000020 with pc 0x80000024 → single entry with pc 0x80000024, has_exception=1. No further requests until redirect; after redirect, fetch resumes.
- rst asserted mid-burst with count=7, outstanding=2 → all state cleared immediately. After release, the first request is at 0x80000000 and late responses are ignored.
